// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sound_pkg
//  Description : Shared types and helpers for the PCM stream player.
//                - player_state_t : playback sequencer states
//                - lanes()        : samples per memory word
//                - MIDSCALE()     : silence level for a given sample width
//  Revision    : 1.0  initial release
// ============================================================================
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } player_state_t;

    // Number of DATA_WIDTH samples packed into one memory word.
    function automatic int lanes(input int fifo_data_width, input int data_width);
        return fifo_data_width / data_width;
    endfunction

    // Mid-scale (silence) code for an unsigned sample of the given width.
    function automatic int MIDSCALE(input int data_width);
        return 1 << (data_width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac
//  Description : Glitch-free PWM audio DAC. A free-running counter is compared
//                against a level that is only reloaded when the counter wraps,
//                so a period is never cut short or stretched mid-cycle.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                aud_en_i      - 0 forces the output low
//                level_i       - unsigned level to play
//                pwm_o         - registered PWM output
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_dac
    import sound_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aud_en_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    output logic                  pwm_o
);

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] MID     = DATA_WIDTH'(MIDSCALE(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] cmp_q;
    logic                  pwm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            cmp_q <= MID;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + DATA_WIDTH'(1);
            // Reload only at wrap so the next period starts with the new level.
            if (cnt_q == CNT_MAX) begin
                cmp_q <= level_i;
            end
            pwm_q <= aud_en_i & (cnt_q < cmp_q);
        end
    end

    assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pcm_stream_player.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_stream_player
//  Description : Fetches packed PCM words from a synchronous sample memory,
//                unpacks them little-endian into DATA_WIDTH samples at a
//                programmable rate, applies a volume shift and drives a PWM
//                audio output. One-shot or looped playback over an inclusive
//                address window.
//  Ports       : clk, rst                 - clock, async active-high reset
//                start, stop              - playback control pulses
//                loop_en, rate_div,
//                start_addr, end_addr     - latched on start
//                aud_en, vol_shift        - live output controls
//                mem_addr, mem_rd_en,
//                mem_rd_data              - sample memory (1-cycle latency)
//                busy, done               - status
//                aud_pwm                  - PWM audio output
//  Revision    : 1.0  initial release
// ============================================================================
module pcm_stream_player
    import sound_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       aud_en,
    input  logic [DIV_WIDTH-1:0]       rate_div,
    input  logic [ADDR_WIDTH-1:0]      start_addr,
    input  logic [ADDR_WIDTH-1:0]      end_addr,
    input  logic [2:0]                 vol_shift,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] mem_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       aud_pwm
);

    localparam int                    LANES     = lanes(FIFO_DATA_WIDTH, DATA_WIDTH);
    localparam int                    LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [DATA_WIDTH-1:0] MID       = DATA_WIDTH'(MIDSCALE(DATA_WIDTH));

    // Address following 'a' inside the window; wraps modulo 2^ADDR_WIDTH and
    // back to the window start after the last address.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] s,
        input logic [ADDR_WIDTH-1:0] e
    );
        return (a == e) ? s : (a + ADDR_WIDTH'(1));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    player_state_t              state_q,    state_d;
    logic                       prime_ph_q, prime_ph_d;   // PRIME cycle 0/1
    logic [DIV_WIDTH-1:0]       rate_q,     rate_d;
    logic [ADDR_WIDTH-1:0]      start_q,    start_d;
    logic [ADDR_WIDTH-1:0]      end_q,      end_d;
    logic                       loop_q,     loop_d;
    logic [DIV_WIDTH-1:0]       cnt_q,      cnt_d;
    logic [LANE_W-1:0]          lane_q,     lane_d;
    logic [FIFO_DATA_WIDTH-1:0] cur_word_q, cur_word_d;
    logic [FIFO_DATA_WIDTH-1:0] nxt_word_q, nxt_word_d;
    logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;   // address of cur_word
    logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;   // also address of nxt_word
    logic                       rd_en_q,    rd_en_d;
    logic                       pend_q,     pend_d;       // read data arrives this cycle
    logic                       last_q,     last_d;       // final sample is playing
    logic [DATA_WIDTH-1:0]      sample_q,   sample_d;
    logic                       done_q,     done_d;

    logic [DIV_WIDTH-1:0]       w_term;
    logic                       w_tick;
    logic [DATA_WIDTH-1:0]      w_lane_sample;

    assign w_term        = (rate_q == '0) ? DIV_WIDTH'(1) : rate_q;
    assign w_tick        = (state_q == PLAY) && (cnt_q == w_term);
    assign w_lane_sample = cur_word_q[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prime_ph_q <= 1'b0;
            rate_q     <= '0;
            start_q    <= '0;
            end_q      <= '0;
            loop_q     <= 1'b0;
            cnt_q      <= '0;
            lane_q     <= '0;
            cur_word_q <= '0;
            nxt_word_q <= '0;
            cur_addr_q <= '0;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            pend_q     <= 1'b0;
            last_q     <= 1'b0;
            sample_q   <= MID;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prime_ph_q <= prime_ph_d;
            rate_q     <= rate_d;
            start_q    <= start_d;
            end_q      <= end_d;
            loop_q     <= loop_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            cur_word_q <= cur_word_d;
            nxt_word_q <= nxt_word_d;
            cur_addr_q <= cur_addr_d;
            mem_addr_q <= mem_addr_d;
            rd_en_q    <= rd_en_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            sample_q   <= sample_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prime_ph_d = prime_ph_q;
        rate_d     = rate_q;
        start_d    = start_q;
        end_d      = end_q;
        loop_d     = loop_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        cur_word_d = cur_word_q;
        nxt_word_d = nxt_word_q;
        cur_addr_d = cur_addr_q;
        mem_addr_d = mem_addr_q;
        rd_en_d    = 1'b0;
        pend_d     = rd_en_q;
        last_d     = last_q;
        sample_d   = sample_q;
        done_d     = 1'b0;

        // Read data lands one cycle after the strobe: the PRIME read fills the
        // current word, every later read is the prefetch for the next word.
        if (pend_q) begin
            if (state_q == PRIME) begin
                cur_word_d = mem_rd_data;
            end else if (state_q == PLAY) begin
                nxt_word_d = mem_rd_data;
            end
        end

        if (stop) begin
            state_d    = IDLE;
            prime_ph_d = 1'b0;
            pend_d     = 1'b0;
            last_d     = 1'b0;
            sample_d   = MID;
        end else begin
            case (state_q)
                IDLE: begin
                    sample_d = MID;
                    if (start) begin
                        state_d    = PRIME;
                        prime_ph_d = 1'b0;
                        rate_d     = rate_div;
                        start_d    = start_addr;
                        end_d      = end_addr;
                        loop_d     = loop_en;
                        mem_addr_d = start_addr;
                        rd_en_d    = 1'b1;
                    end
                end

                PRIME: begin
                    if (!prime_ph_q) begin
                        // Prefetch the second word while the first is in flight.
                        prime_ph_d = 1'b1;
                        mem_addr_d = next_addr(start_q, start_q, end_q);
                        rd_en_d    = 1'b1;
                    end else begin
                        state_d    = PLAY;
                        prime_ph_d = 1'b0;
                        cur_addr_d = start_q;
                        lane_d     = '0;
                        cnt_d      = '0;
                        last_d     = 1'b0;
                    end
                end

                PLAY: begin
                    if (w_tick) begin
                        cnt_d = '0;
                        if (last_q) begin
                            // Final sample has held a full period.
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            last_d   = 1'b0;
                            sample_d = MID;
                        end else begin
                            sample_d = w_lane_sample;
                            if (lane_q != LAST_LANE) begin
                                lane_d = lane_q + LANE_W'(1);
                            end else begin
                                lane_d     = '0;
                                cur_word_d = nxt_word_q;
                                cur_addr_d = mem_addr_q;
                                if ((cur_addr_q == end_q) && !loop_q) begin
                                    last_d = 1'b1;
                                end else begin
                                    mem_addr_d = next_addr(mem_addr_q, start_q, end_q);
                                    rd_en_d    = 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_WIDTH'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Volume: centre on midscale, arithmetic shift, re-bias. The shifted
    // magnitude never exceeds the unshifted one, so the result stays in range.
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH:0] w_centered;
    logic signed [DATA_WIDTH:0] w_shifted;
    logic [DATA_WIDTH-1:0]      w_level;

    assign w_centered = $signed({1'b0, sample_q}) - $signed({1'b0, MID});
    assign w_shifted  = w_centered >>> vol_shift;
    assign w_level    = w_shifted[DATA_WIDTH-1:0] + MID;

    pwm_dac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dac (
        .clk      (clk),
        .rst      (rst),
        .aud_en_i (aud_en),
        .level_i  (w_level),
        .pwm_o    (aud_pwm)
    );

    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = rd_en_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_stream_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_stream_player
//  Description : Self-checking bench for pcm_stream_player. Expected sample
//                sequences come from a word-walking model of the address
//                window; PWM duty expectations come from a hand-filled table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcm_stream_player;

    localparam int DW  = 8;
    localparam int FDW = 32;
    localparam int AW  = 16;
    localparam int VW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, stop, loop_en, aud_en;
    logic [VW-1:0]  rate_div;
    logic [AW-1:0]  start_addr, end_addr;
    logic [2:0]     vol_shift;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd_en;
    logic [FDW-1:0] mem_rd_data = '0;
    logic           busy, done, aud_pwm;

    pcm_stream_player #(
        .DATA_WIDTH      (DW),
        .FIFO_DATA_WIDTH (FDW),
        .ADDR_WIDTH      (AW),
        .DIV_WIDTH       (VW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .aud_en      (aud_en),
        .rate_div    (rate_div),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .vol_shift   (vol_shift),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .aud_pwm     (aud_pwm)
    );

    always #5 clk = ~clk;

    // Synchronous sample memory
    logic [FDW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;

    always @(negedge clk) begin
        if (done)      done_cnt++;
        if (mem_rd_en) rd_cnt++;
    end

    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic [DW-1:0] smp;
        logic [2:0]    vs;
        logic          en;
        int            exp_high;
    } duty_vec_t;

    duty_vec_t dv [9];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Expected samples: walk words from sa up to ea (inclusive, wrapping
    // modulo 2^AW) and emit lanes little-endian, repeated 'loops' times.
    task automatic model_seq(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input int loops);
        logic [AW-1:0]  a;
        logic [FDW-1:0] w;
        exp_q.delete();
        for (int l = 0; l < loops; l++) begin
            a = sa;
            for (int g = 0; g < 65536; g++) begin
                w = mem[a];
                for (int i = 0; i < FDW / DW; i++) exp_q.push_back(w[i*DW +: DW]);
                if (a == ea) break;
                a = a + 16'd1;
            end
        end
    endtask

    task automatic run_play(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                            input logic [VW-1:0] rd, input logic lp,
                            input int loops, input logic poke);
        int p, n, d0, k, t_end;
        model_seq(sa, ea, loops);
        p  = ((rd == 0) ? 1 : int'(rd)) + 1;
        n  = exp_q.size();
        d0 = done_cnt;
        k  = 0;
        start_addr = sa; end_addr = ea; rate_div = rd; loop_en = lp;
        start = 1'b1;
        step(1);
        start = 1'b0;
        // These are latched at start and must no longer matter.
        start_addr = AW'($urandom); end_addr = AW'($urandom);
        rate_div   = VW'($urandom); loop_en  = ~lp;
        t_end = lp ? (2 + n * p) : (2 + (n + 1) * p - 1);
        for (int t = 1; t <= t_end; t++) begin
            step(1);
            start = (poke && t == 3);
            if (k < n && t == 2 + (k + 1) * p) begin
                check("sample", 32'(dut.sample_q), 32'(exp_q[k]));
                k++;
            end
        end
        start = 1'b0;
        if (lp) begin
            stop = 1'b1;
            step(1);
            stop = 1'b0;
            check("stop_busy", 32'(busy), 32'd0);
            check("stop_sample", 32'(dut.sample_q), 32'h80);
            check("stop_rd_en", 32'(mem_rd_en), 32'd0);
            step(1);
            check("loop_no_done", 32'(done_cnt - d0), 32'd0);
        end else begin
            check("busy_before_end", 32'(busy), 32'd1);
            step(1);
            check("done_pulse", 32'(done), 32'd1);
            check("busy_fall", 32'(busy), 32'd0);
            check("end_midscale", 32'(dut.sample_q), 32'h80);
            step(1);
            check("done_single", 32'(done), 32'd0);
            check("done_count", 32'(done_cnt - d0), 32'd1);
        end
    endtask

    initial begin
        int hi, r0;
        logic [AW-1:0] sa;

        for (int i = 0; i < 65536; i++) mem[i] = $urandom;

        dv[0] = '{8'h40, 3'd0, 1'b1, 64};
        dv[1] = '{8'h00, 3'd1, 1'b1, 64};
        dv[2] = '{8'hFF, 3'd1, 1'b1, 191};
        dv[3] = '{8'hFF, 3'd7, 1'b1, 128};
        dv[4] = '{8'h00, 3'd0, 1'b1, 0};
        dv[5] = '{8'hFF, 3'd0, 1'b1, 255};
        dv[6] = '{8'h10, 3'd2, 1'b1, 100};
        dv[7] = '{8'h40, 3'd0, 1'b0, 0};
        dv[8] = '{8'hC0, 3'd3, 1'b1, 136};

        rst = 1'b1; start = 0; stop = 0; loop_en = 0; aud_en = 0;
        rate_div = '0; start_addr = '0; end_addr = '0; vol_shift = '0;
        step(3);
        check("reset_outputs", {busy, done, mem_rd_en, aud_pwm, mem_addr}, 32'd0);
        check("reset_sample", 32'(dut.sample_q), 32'h80);
        rst = 1'b0;
        step(2);

        // 1: one-shot, with a start pulse injected mid-play
        mem[0] = 32'h40302010;
        mem[1] = 32'h80706050;
        run_play(16'd0, 16'd1, 16'd3, 1'b0, 1, 1'b1);
        step(3);

        // 2: looped, three passes then stop
        run_play(16'd0, 16'd1, 16'd3, 1'b1, 3, 1'b0);
        step(3);

        // 6: address wrap through 0xFFFF, minimum period
        run_play(16'hFFFF, 16'h0000, 16'd0, 1'b0, 1, 1'b0);
        step(3);

        // 5b: start and stop together
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        step(3);
        check("startstop_idle", {busy, mem_rd_en}, 32'd0);

        // 5c: asynchronous reset mid-play
        start_addr = 16'd0; end_addr = 16'd1; rate_div = 16'd3; loop_en = 1'b1;
        aud_en = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        step(12);
        #3 rst = 1'b1;
        #1 check("async_reset", {busy, done, mem_rd_en, aud_pwm, mem_addr}, 32'd0);
        check("async_reset_sample", 32'(dut.sample_q), 32'h80);
        step(2);
        rst = 1'b0;
        step(2);

        // 3/4: PWM duty and volume table
        for (int v = 0; v < 9; v++) begin
            mem[16] = {4{dv[v].smp}};
            mem[17] = {4{dv[v].smp}};
            vol_shift = dv[v].vs; aud_en = dv[v].en;
            start_addr = 16'd16; end_addr = 16'd17; rate_div = 16'd3; loop_en = 1'b1;
            start = 1'b1; step(1); start = 1'b0;
            step(600);
            hi = 0;
            r0 = rd_cnt;
            for (int c = 0; c < 256; c++) begin
                step(1);
                if (aud_pwm) hi++;
            end
            check("pwm_duty", 32'(hi), 32'(dv[v].exp_high));
            check("reads_per_period", 32'(rd_cnt - r0), 32'd16);
            stop = 1'b1; step(1); stop = 1'b0;
            step(2);
        end
        aud_en = 1'b0;

        // Randomized windows against the model
        for (int r = 0; r < 10; r++) begin
            sa = AW'($urandom);
            vol_shift = 3'($urandom);
            run_play(sa, sa + AW'($urandom_range(0, 3)), VW'($urandom_range(0, 5)),
                     1'b0, 1, 1'($urandom));
            step(2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
